// File: rtl/acc12_pkg.sv
// Shared definitions for the acc12_seq accumulator stage: opcodes,
// FSM state type, datapath width and signed saturation limits.
package acc12_pkg;

   localparam int unsigned ACC_W = 12;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [ACC_W-1:0] SAT_MAX = 12'h7FF;
   localparam logic [ACC_W-1:0] SAT_MIN = 12'h800;

endpackage

// File: rtl/acc12_seq_cla.sv
// 12-bit carry-lookahead adder: three 4-bit lookahead groups joined by a
// second-level group carry network. Purely combinational.
module acc12_seq_cla
   import acc12_pkg::*;
(
   input  logic [ACC_W-1:0] a_i,
   input  logic [ACC_W-1:0] b_i,
   input  logic             cin_i,
   output logic [ACC_W-1:0] sum_o,
   output logic             cout_o
);

   logic [ACC_W-1:0] g;
   logic [ACC_W-1:0] p;
   logic [ACC_W-1:0] c;
   logic [2:0]       gg;
   logic [2:0]       pg;
   logic [3:0]       cg;

   // Bit and group generate/propagate, group carries, then in-group carries
   always_comb begin
      g  = a_i & b_i;
      p  = a_i ^ b_i;
      gg = '0;
      pg = '0;
      cg = '0;
      c  = '0;
      for (int unsigned k = 0; k < 3; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         pg[k] = &p[4*k +: 4];
      end
      cg[0] = cin_i;
      cg[1] = gg[0] | (pg[0] & cin_i);
      cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin_i);
      cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
            | (pg[2] & pg[1] & pg[0] & cin_i);
      for (int unsigned k = 0; k < 3; k++) begin
         c[4*k]   = cg[k];
         c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
      end
      sum_o  = p ^ c;
      cout_o = cg[3];
   end

endmodule

// File: rtl/acc12_seq.sv
// acc12_seq: sequential accumulator stage. Accepts LOAD/ADD/SUB/CLEAR on a
// valid/ready input, executes through a single 12-bit CLA (SUB = inverted
// operand + cin), and holds the result on a valid/ready output.
// Optional macro ACC12_SAT_EN clamps overflowing ADD/SUB results to the
// signed limits instead of wrapping.
module acc12_seq
   import acc12_pkg::*;
#(
   parameter int unsigned   W        = 12,
   parameter logic [W-1:0]  INIT_VAL = '0
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_op,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_acc,
   output logic         out_carry,
   output logic         out_ovf
);

   if (W != ACC_W) begin : g_w_check
      $error("acc12_seq: W must be 12");
   end

   state_e         state_q;
   logic [1:0]     op_q;
   logic [W-1:0]   data_q;
   logic [W-1:0]   acc_q;
   logic           carry_q;
   logic           ovf_q;
   logic           out_valid_q;
   logic           in_ready_q;

   logic [W-1:0]   add_b;
   logic           add_cin;
   logic [W-1:0]   add_sum;
   logic           add_cout;
   logic           ovf_raw;
   logic [W-1:0]   acc_d;
   logic           carry_d;
   logic           ovf_d;

   acc12_seq_cla u_cla (
      .a_i    (acc_q),
      .b_i    (add_b),
      .cin_i  (add_cin),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // Adder operand selection and per-opcode result/flag selection for EXEC
   always_comb begin
      add_cin = (op_q == OP_SUB);
      add_b   = add_cin ? ~data_q : data_q;
      ovf_raw = (acc_q[W-1] == add_b[W-1]) && (add_sum[W-1] != acc_q[W-1]);
      acc_d   = INIT_VAL;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (op_q)
         OP_LOAD: acc_d = data_q;
         OP_ADD, OP_SUB: begin
            carry_d = add_cout;
            ovf_d   = ovf_raw;
`ifdef ACC12_SAT_EN
            if (ovf_raw)
               acc_d = acc_q[W-1] ? SAT_MIN : SAT_MAX;
            else
               acc_d = add_sum;
`else
            acc_d = add_sum;
`endif
         end
         default: acc_d = INIT_VAL;
      endcase
   end

   // IDLE -> EXEC -> RESP handshake FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_LOAD;
         data_q      <= '0;
         acc_q       <= INIT_VAL;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  op_q       <= in_op;
                  data_q     <= in_data;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               acc_q       <= acc_d;
               carry_q     <= carry_d;
               ovf_q       <= ovf_d;
               out_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_acc   = acc_q;
   assign out_carry = carry_q;
   assign out_ovf   = ovf_q;

endmodule

// File: doc/acc12_seq.md
Name: acc12_seq

Overview:
- Sequential accumulator stage that consumes the 12-bit carry-lookahead adder.
- Accepts a stream of opcode + 12-bit operands on a valid/ready handshake and drives the adder with the accumulator and the operand (inverted operand and cin=1 for subtract).
- Registers sum/carry/overflow back into the accumulator and presents each result on an output valid/ready handshake.
- Sits between the operand-issue logic and the result consumer in the datapath.

Parameters:
- W, 12, datapath width; the adder sub-module is 12 bits, so only 12 is supported. Elaboration error if W != 12.
- INIT_VAL, 12'h000, accumulator value after reset and after CLEAR.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand/opcode valid
- in_ready  output  1  stage can accept
- in_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
- in_data  input  W  operand
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_acc  output  W  accumulator after the operation
- out_carry  output  1  adder carry-out (ADD: carry; SUB: 1 = no borrow); 0 for LOAD/CLEAR
- out_ovf  output  1  signed two's-complement overflow; 0 for LOAD/CLEAR

Behaviour:
- Reset values: acc=INIT_VAL, state=IDLE, out_valid=0, out_carry=0, out_ovf=0, out_acc=INIT_VAL, in_ready=1.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture op_q/data_q and go to EXEC.
- EXEC (one cycle):
  - in_ready=0.
  - Adder inputs: a=acc, b=(op==SUB)?~data_q:data_q, cin=(op==SUB).
  - ovf = (a[11]==b[11]) && (sum[11]!=a[11]), using the post-inversion b.
  - LOAD: acc<=data_q. ADD/SUB: acc<=sum. CLEAR: acc<=INIT_VAL.
  - Register out_acc/out_carry/out_ovf. Go to RESP.
- RESP:
  - out_valid=1, in_ready=0.
  - Outputs are held stable until out_ready=1, then go to IDLE with out_valid=0 on the next cycle.
- Latency: accept edge to out_valid high is 2 cycles. Throughput is one op per 3 cycles with out_ready tied high.
- out_ready is ignored outside RESP. in_valid is ignored outside IDLE; there is no buffering.
- Width/arithmetic:
  - All sums are modulo 2^12 and wrap-around is silent.
  - carry and ovf are reported, not acted on, unless the optional feature is enabled.
- Reset asserted in any state (including EXEC/RESP mid-handshake):
  - Next edge returns to IDLE with reset values.
  - The pending result is dropped and no out_valid pulse is produced.
- in_op/in_data may change freely after acceptance because they are registered at accept.

Optional Feature:
- Macro: ACC12_SAT_EN.
- Defined:
  - ADD/SUB results with ovf=1 are clamped to signed limits: 12'h7FF if a[11]==0, else 12'h800.
  - out_ovf still reports 1.
  - out_carry is unchanged from the raw adder carry.
- Undefined: wrapping results as described above; no clamp logic is instantiated.

Decomposition:
- Shared package acc12_pkg holds:
  - opcode localparams OP_LOAD/OP_ADD/OP_SUB/OP_CLEAR (2-bit)
  - state encodings ST_IDLE/ST_EXEC/ST_RESP
  - data width constant ACC_W=12
  - saturation constants SAT_MAX=12'h7FF, SAT_MIN=12'h800
- One sub-module: the existing 12-bit carry-lookahead adder, instantiated once combinationally in EXEC.
- No second adder. Subtraction uses operand inversion plus cin.

Test Plan:
- Reset, LOAD 0x0FF, out_ready=1 -> out_valid 2 cycles after accept, out_acc=0x0FF, carry=0, ovf=0.
- LOAD 0xFFF; ADD 0x001 -> out_acc=0x000, carry=1, ovf=0. LOAD 0x7FF; ADD 0x001 -> out_acc=0x800, carry=0, ovf=1; with ACC12_SAT_EN -> out_acc=0x7FF, ovf=1.
- LOAD 0x005; SUB 0x007 -> out_acc=0xFFE, carry=0, ovf=0. Then SUB 0xFFE -> out_acc=0x000, carry=1.
- Backpressure: hold out_ready=0 for 5 cycles in RESP while in_valid=1 with a new op:
  - out_acc/carry/ovf stay stable and in_ready=0 throughout.
  - The new op is accepted only in IDLE after the handshake.
- Assert rst during EXEC of ADD 0x010 (acc=0x020) -> next cycle state IDLE, out_valid=0, out_acc=INIT_VAL, no result emitted.
- CLEAR after accumulating 0x123 -> out_acc=INIT_VAL (0x000), carry=0, ovf=0.
